// File: rtl/aes_outport_pkg.sv
// Shared types and sizing helpers for the AES output port stream block.
package aes_outport_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  localparam int PACE_W = 16;

  function automatic int words_per_blk(input int blk_w, input int in_w);
    return blk_w / in_w;
  endfunction

  function automatic int beats_per_blk(input int blk_w, input int out_w);
    return blk_w / out_w;
  endfunction

  // Index width for a 0..n-1 counter or pointer; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy counter that must also represent n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aes_outport_bank.sv
// Block buffer: assembles IN_W words into BLK_W entries (first word lands in the MS bits)
// and hands committed entries to the output side in arrival order.
module aes_outport_bank
  import aes_outport_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int BLK_W = 128,
  parameter int DEPTH = 2,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             release_blk,
  output logic             full,
  output logic             commit,
  output logic [CNT_W-1:0] count,
  output logic [BLK_W-1:0] rd_block
);

  localparam int WPB   = words_per_blk(BLK_W, IN_W);
  localparam int WC_W  = idx_w(WPB);
  localparam int PTR_W = idx_w(DEPTH);

  logic [BLK_W-1:0] mem [DEPTH];
  logic [WC_W-1:0]  wcnt;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr;

  // A partially assembled entry always sits in a free slot, so only full blocks stall input.
  assign full     = (count == CNT_W'(DEPTH));
  assign wr       = in_valid & ~full;
  assign commit   = wr & (wcnt == WC_W'(WPB - 1));
  assign rd_block = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr][BLK_W - 1 - int'(wcnt) * IN_W -: IN_W] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wcnt <= (wcnt == WC_W'(WPB - 1)) ? '0 : wcnt + 1'b1;
      if (commit) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (release_blk) rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({commit, release_blk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_outport_stream.sv
// AES output port: buffers BLK_W result blocks and serialises them MSB-first as OUT_W beats.
// Define AES_OUTPORT_STROBE_EN for legacy pad pacing (2^div_bits cycles per beat, out_ready ignored).
module aes_outport_stream
  import aes_outport_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int BLK_W = 128,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       div_bits,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int BPB   = beats_per_blk(BLK_W, OUT_W);
  localparam int BC_W  = idx_w(BPB);
  localparam int CNT_W = cnt_w(DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [BLK_W-1:0] shreg;
  logic [BC_W-1:0]  bcnt;
  logic             beat_done;
  logic             last_beat;
  logic             release_blk;
  logic             full;
  logic             commit;
  logic [CNT_W-1:0] count;
  logic [BLK_W-1:0] rd_block;

  aes_outport_bank #(
    .IN_W  (IN_W),
    .BLK_W (BLK_W),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .release_blk (release_blk),
    .full        (full),
    .commit      (commit),
    .count       (count),
    .rd_block    (rd_block)
  );

  assign in_ready  = ~full;
  assign last_beat = (bcnt == BC_W'(BPB - 1));
  assign out_data  = (state == SHIFT) ? shreg[BLK_W-1 -: OUT_W] : '0;
  assign out_last  = (state == SHIFT) & last_beat;

`ifdef AES_OUTPORT_STROBE_EN
  logic [3:0]        div_q;
  logic [PACE_W-1:0] pace;
  logic [PACE_W-1:0] period;
  logic              pace_last;
  logic              strobe_hi;
  logic              unused_ready;

  assign unused_ready = out_ready;
  assign period       = PACE_W'(1) << div_q;
  assign pace_last    = (pace == period - 1'b1);
  assign strobe_hi    = (div_q == 4'd0) | (pace < (period >> 1));
  assign out_valid    = (state == SHIFT) & strobe_hi;
  assign beat_done    = (state == SHIFT) & pace_last;

  // Pace period is latched at LOAD so a block never changes speed mid-flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      pace  <= '0;
    end else if (state == LOAD) begin
      div_q <= div_bits;
      pace  <= '0;
    end else if (state == SHIFT) begin
      pace <= pace_last ? '0 : pace + 1'b1;
    end
  end
`else
  logic unused_div;

  assign unused_div = ^div_bits;
  assign out_valid  = (state == SHIFT);
  assign beat_done  = out_valid & out_ready;
`endif

  // A commit landing in this very cycle counts as a waiting block, saving a cycle of latency.
  always_comb begin
    state_nxt   = state;
    release_blk = 1'b0;
    case (state)
      IDLE:  if ((count != '0) || commit) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: begin
        if (beat_done && last_beat) begin
          release_blk = 1'b1;
          state_nxt   = ((count > CNT_W'(1)) || commit) ? LOAD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) bcnt <= '0;
      else if (beat_done) bcnt <= bcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) shreg <= rd_block;
    else if (beat_done) shreg <= shreg << OUT_W;
  end

endmodule

// File: tb/tb_aes_outport_stream.sv
// Directed bench for aes_outport_stream: block table plus backpressure, collision, reset and sweep sequences.
module tb_aes_outport_stream;
  import aes_outport_pkg::*;

  typedef struct {
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [127:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  div_bits;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  logic [3:0]  div_bits1;
  logic [63:0] in_data1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] out_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic        out_last1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  vec_t        tbl [4];
  logic [7:0]  bq [$];
  logic        lq [$];
  int          cq [$];
  logic [15:0] bq1 [$];
  logic        lq1 [$];
  int          cq1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_outport_stream u0 (
    .clk(clk), .rst(rst), .div_bits(div_bits), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  aes_outport_stream #(.IN_W(64), .OUT_W(16), .BLK_W(128), .DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .div_bits(div_bits1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1)
  );

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid && out_ready) begin
        bq.push_back(out_data);
        lq.push_back(out_last);
        cq.push_back(cyc);
      end
      if (out_valid1 && out_ready1) begin
        bq1.push_back(out_data1);
        lq1.push_back(out_last1);
        cq1.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    bq.delete(); lq.delete(); cq.delete();
    bq1.delete(); lq1.delete(); cq1.delete();
  endtask

  task automatic send_word(input logic [31:0] w, output int acc);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    tick();
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_word1(input logic [63:0] w, output int acc);
    int t;
    t = 0;
    in_data1  = w;
    in_valid1 = 1'b1;
    while (!in_ready1 && t < 300) begin
      tick();
      t++;
    end
    if (!in_ready1) check("in_ready1_wait", in_ready1, 1);
    tick();
    acc       = cyc;
    in_valid1 = 1'b0;
  endtask

  task automatic send_block(input vec_t v, output int acc);
    int a;
    send_word(v.w0, a);
    send_word(v.w1, a);
    send_word(v.w2, a);
    send_word(v.w3, acc);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (bq.size() < n && t < budget) begin
      tick();
      t++;
    end
  endtask

  task automatic gather(input int base, output logic [127:0] v);
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], (base + i < bq.size()) ? bq[base + i] : 8'h00};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    int acc;
    int a;
    int nl;
    logic [127:0] got;

    tbl[0] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
               128'h00112233_44556677_8899AABB_CCDDEEFF};
    tbl[1] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
               128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A,
               128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A};
    tbl[3] = '{32'h80000001, 32'h7FFFFFFE, 32'h00FF00FF, 32'hFF00FF00,
               128'h80000001_7FFFFFFE_00FF00FF_FF00FF00};

    rst = 1'b0; div_bits = 4'd0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    div_bits1 = 4'd0; in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

`ifdef AES_OUTPORT_STROBE_EN
    begin
      int vbad;
      int hi;
      // div_bits=3: 8-cycle beats, strobe high for the first 4; div_bits changed mid-block must not matter
      div_bits = 4'd3;
      send_block(tbl[0], acc);
      check("strobe_load_state", u0.state, LOAD);
      tick();
      div_bits = 4'd5;
      vbad = 0;
      hi = 0;
      for (int j = 0; j < 128; j++) begin
        if (out_valid !== ((j % 8) < 4)) vbad++;
        if (out_valid === 1'b1) hi++;
        if (out_last !== ((j / 8) == 15)) vbad++;
        if ((j % 8) == 0) check($sformatf("strobe3_beat%0d", j / 8), out_data, tbl[0].exp[127 - 8 * (j / 8) -: 8]);
        if ((j % 8) == 7) check($sformatf("strobe3_hold%0d", j / 8), out_data, tbl[0].exp[127 - 8 * (j / 8) -: 8]);
        tick();
      end
      check("strobe3_pattern_errors", vbad, 0);
      check("strobe3_high_cycles", hi, 64);
      check("strobe3_end_valid", out_valid, 0);
      check("strobe3_end_state", u0.state, IDLE);

      // div_bits=0: strobe high on every SHIFT cycle, one beat per cycle
      div_bits = 4'd0;
      send_block(tbl[1], acc);
      tick();
      vbad = 0;
      for (int j = 0; j < 16; j++) begin
        if (out_valid !== 1'b1) vbad++;
        check($sformatf("strobe0_beat%0d", j), out_data, tbl[1].exp[127 - 8 * j -: 8]);
        tick();
      end
      check("strobe0_valid_errors", vbad, 0);
      check("strobe0_end_valid", out_valid, 0);
    end
`else
    // Table of single blocks with a free-running sink
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      clear_q();
      send_block(tbl[v], acc);
      wait_beats(16, 60);
      repeat (3) tick();
      check($sformatf("blk%0d_beat_count", v), bq.size(), 16);
      gather(0, got);
      check($sformatf("blk%0d_data", v), got, tbl[v].exp);
      check($sformatf("blk%0d_first_latency", v), (cq.size() > 0) ? cq[0] - acc : -1, 1);
      check($sformatf("blk%0d_back_to_back", v), (cq.size() == 16) ? cq[15] - cq[0] : -1, 15);
      nl = 0;
      foreach (lq[i]) if (lq[i]) nl++;
      check($sformatf("blk%0d_last_count", v), nl, 1);
      check($sformatf("blk%0d_last_pos", v), (lq.size() == 16) ? lq[15] : 1'b0, 1);
    end

    // Backpressure: two blocks fill the buffer, the third waits
    clear_q();
    out_ready = 1'b0;
    send_block(tbl[0], acc);
    send_block(tbl[1], acc);
    check("bp_in_ready_full", in_ready, 0);
    repeat (2) tick();
    check("bp_out_data_hold", out_data, 8'h00);
    check("bp_out_valid", out_valid, 1);
    fork
      send_block(tbl[2], a);
      begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("bp_in_ready_low%0d", k), in_ready, 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_beats(48, 200);
    repeat (3) tick();
    check("bp_beat_count", bq.size(), 48);
    gather(0, got);
    check("bp_blk0", got, tbl[0].exp);
    gather(16, got);
    check("bp_blk1", got, tbl[1].exp);
    gather(32, got);
    check("bp_blk2", got, tbl[2].exp);

    // Commit of the next block on the same edge as the last beat of the current one
    clear_q();
    send_block(tbl[1], acc);
    repeat (13) tick();
    send_word(tbl[3].w0, a);
    send_word(tbl[3].w1, a);
    send_word(tbl[3].w2, a);
    send_word(tbl[3].w3, a);
    check("sim_count", u0.u_bank.count, 1);
    check("sim_state", u0.state, LOAD);
    wait_beats(32, 60);
    repeat (3) tick();
    check("sim_beat_count", bq.size(), 32);
    check("sim_collision_edge", a - acc, 17);
    check("sim_one_bubble", (cq.size() == 32) ? cq[16] - cq[15] : -1, 2);
    gather(0, got);
    check("sim_blk_a", got, tbl[1].exp);
    gather(16, got);
    check("sim_blk_b", got, tbl[3].exp);

    // Reset during beat 5 with a partial block buffered
    clear_q();
    send_block(tbl[0], acc);
    send_word(tbl[2].w0, a);
    send_word(tbl[2].w1, a);
    send_word(tbl[2].w2, a);
    repeat (3) tick();
    check("rst_pre_beat5", out_data, 8'h55);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrst");
    check("midrst_count", u0.u_bank.count, 0);
    rst = 1'b1;
    clear_q();
    send_block(tbl[3], acc);
    wait_beats(16, 60);
    repeat (4) tick();
    check("rst_fresh_count", bq.size(), 16);
    gather(0, got);
    check("rst_fresh_data", got, tbl[3].exp);

    // Wider words and beats: 2 words and 8 beats per block
    out_ready1 = 1'b1;
    for (int v = 0; v < 2; v++) begin
      int t;
      clear_q();
      send_word1({tbl[v].w0, tbl[v].w1}, a);
      send_word1({tbl[v].w2, tbl[v].w3}, acc);
      t = 0;
      while (bq1.size() < 8 && t < 40) begin
        tick();
        t++;
      end
      repeat (3) tick();
      check($sformatf("sw%0d_beat_count", v), bq1.size(), 8);
      got = '0;
      foreach (bq1[i]) got = {got[111:0], bq1[i]};
      check($sformatf("sw%0d_data", v), got, tbl[v].exp);
      check($sformatf("sw%0d_first_latency", v), (cq1.size() > 0) ? cq1[0] - acc : -1, 1);
      nl = 0;
      foreach (lq1[i]) if (lq1[i]) nl++;
      check($sformatf("sw%0d_last_count", v), nl, 1);
      check($sformatf("sw%0d_last_pos", v), (lq1.size() == 8) ? lq1[7] : 1'b0, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_outport_stream.md
# aes_outport_stream

Parametrised successor to the AES output port. Collects `IN_W`-bit result words from the AES core into `BLK_W`-bit blocks and serialises each block MSB-first as `OUT_W`-bit beats. A `DEPTH`-entry block buffer lets the core deliver the next result while the previous one drains, with `in_ready` backpressure. It sits between the AES datapath and the chip pad interface.

## Interface
- `IN_W`, 32: input word width; must divide `BLK_W`.
- `OUT_W`, 8: output beat width; must divide `BLK_W`.
- `BLK_W`, 128: block width.
- `DEPTH`, 2: number of block buffers; must be a power of two and at least 1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `div_bits`  in  4  beat pacing exponent; used only with `AES_OUTPORT_STROBE_EN`.
- `in_data`  in  `IN_W`  result word; the first word of a block is the MS word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  a word can be accepted this cycle.
- `out_data`  out  `OUT_W`  current beat.
- `out_valid`  out  1  beat valid, or the pacing strobe in strobe mode.
- `out_ready`  in  1  sink accepts the beat; ignored in strobe mode.
- `out_last`  out  1  current beat is the last beat of its block.

## Operation
- A word transfers when `in_valid & in_ready`. `WPB = BLK_W/IN_W` words make one block.
  - Word k goes to bits `[BLK_W-1-k*IN_W -: IN_W]`.
  - The write word counter wraps at `WPB`. On its last word the entry is committed and the write pointer advances.
- `in_ready = (count < DEPTH)`. A partially filled entry always owns a free slot.
- Commit and release in the same cycle leave `count` unchanged and raise no error.
- Output FSM states:
  - IDLE: stays in IDLE while `count == 0`. Goes to LOAD when `count > 0`.
  - LOAD: copies the read entry into the shift register and clears the beat counter. Goes to SHIFT.
  - SHIFT: presents `shreg[BLK_W-1 -: OUT_W]`. When a beat completes, shifts left by `OUT_W` and increments the beat counter.
  - At the end of SHIFT, after beat `BPB-1` (`BPB = BLK_W/OUT_W`) completes:
    - release the entry and advance the read pointer;
    - go to LOAD if another committed block exists (counting one committed in the same cycle), else go to IDLE.
- `out_last` is high during beat `BPB-1`.
- Handshake mode (macro undefined):
  - `out_valid` is high in SHIFT.
  - A beat completes on `out_valid & out_ready`.
  - `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_last=0`, `out_data=0`.
  - Pointers, counters and `count` are 0. FSM state is IDLE.
  - Buffer contents are not reset.
- Reset mid-operation discards all buffered and partial blocks. The next word accepted after reset is word 0 of a new block.

## Timing
- The last word of a block is accepted in cycle N. Commit is at the N edge.
  - With the FSM in IDLE it reaches LOAD in N+1.
  - The first beat is valid in N+2.
- Handshake mode, continuous `out_ready`: one beat per cycle.
  - A block lasts `BPB` cycles, then one LOAD bubble.
  - Throughput is `BPB` beats per `BPB+1` cycles.
- `in_ready` falls in the cycle after the commit that fills the last free entry. It rises in the cycle after the release.

## Configuration
- `AES_OUTPORT_STROBE_EN` defined (legacy pad pacing):
  - Each beat lasts `P = 2^div_bits` cycles, counted by a 16-bit pace counter.
  - `out_valid` is high for the first `P/2` cycles of the beat and low for the rest.
  - When `div_bits == 0`, `P = 1` and `out_valid` is high every cycle of the beat.
  - `out_ready` is ignored; the beat completes when the pace counter reaches `P-1`.
  - `div_bits` is sampled at LOAD and held for the whole block.
- `AES_OUTPORT_STROBE_EN` undefined:
  - Handshake mode only. `div_bits` is unused and the pace counter is not built.

## Structure
- Package `aes_outport_pkg` holds:
  - the FSM state enum `{IDLE, LOAD, SHIFT}`;
  - helper functions `words_per_blk` and `beats_per_blk`;
  - the `$clog2`-based pointer and counter width constants.
- Sub-module `aes_outport_bank`:
  - the `DEPTH x BLK_W` buffer, write and read pointers, `count`, and the word-assembly counter;
  - exports `full`, `count` and `rd_block`, and takes a `release` input.
- The top level holds the output FSM, the shift register and the pacing logic.

## Test plan
- Default parameters, handshake mode:
  - Stimulus: words `00112233`, `44556677`, `8899AABB`, `CCDDEEFF`, `out_ready=1`.
  - Required: beats `00` through `FF` in 16 consecutive cycles, first beat 2 cycles after word 3. `out_last` is high only with `FF`.
- Backpressure:
  - Stimulus: `out_ready=0` with 3 blocks offered, `DEPTH=2`.
  - Required: `in_ready` drops after block 2 and `out_data` holds `00`. Releasing `out_ready` drains all 48 beats in order with no loss.
- Simultaneous events:
  - Stimulus: a block commit coincides with the release of the last beat, with `count=1`.
  - Required: `count` stays 1, the FSM goes to LOAD, and there is exactly one bubble cycle.
- Strobe mode:
  - Stimulus: `div_bits=3`.
  - Required: each beat lasts 8 cycles with `out_valid` high for 4, and a block lasts 128 cycles.
  - Stimulus: `div_bits=0`.
  - Required: `out_valid` is high continuously during SHIFT.
- Reset:
  - Stimulus: deassert `rst` after word 2 and during beat 5 of a prior block.
  - Required: outputs return to reset values on the next edge. A fresh 4-word block after reset is emitted intact.
- Parameter sweep:
  - Stimulus: `IN_W=64`, `OUT_W=16`, `DEPTH=4`.
  - Required: 2 words per block and 8 beats per block, with data ordering correct.
